// File: rtl/rca_seq_ctrl.sv
// rca_seq_ctrl: multi-cycle W-bit adder built from one shared N-bit
// ripple-carry slice. Operands are captured on a valid/ready handshake,
// the slice is applied K = W/N times (least significant slice first)
// with the carry held in a register between cycles, and the result is
// offered on a second valid/ready handshake.

// rca: plain N-bit ripple-carry adder used as the only arithmetic datapath.
module rca #(
    parameter int N = 8
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_cin,
    output logic [N-1:0] o_sum,
    output logic         o_cout
);

    // Ripple the carry bit by bit from the LSB upwards.
    always_comb begin
        logic w_ripple;
        w_ripple = i_cin;
        o_sum    = '0;
        for (int i = 0; i < N; i++) begin
            o_sum[i] = i_a[i] ^ i_b[i] ^ w_ripple;
            w_ripple = (i_a[i] & i_b[i]) | (w_ripple & (i_a[i] ^ i_b[i]));
        end
        o_cout = w_ripple;
    end

endmodule

module rca_seq_ctrl #(
    parameter int W = 32,
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         busy
);

    // Guarded so a bad N still elaborates far enough to report the error.
    localparam int K  = (N >= 1) ? (W / N) : 1;
    localparam int CW = (K > 1) ? $clog2(K) : 1;
    localparam logic [CW-1:0] LAST_SLICE = CW'(K - 1);

    if (N < 1) begin : g_badSliceWidth
        $error("rca_seq_ctrl: slice width N must be at least 1");
    end else if ((W % N) != 0) begin : g_badTotalWidth
        $error("rca_seq_ctrl: operand width W must be a multiple of N");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_carry;
    logic [W-1:0]    r_opA;
    logic [W-1:0]    r_opB;
    logic [W-1:0]    r_sum;
    logic            r_cout;
    logic            r_inReady;
    logic            r_outValid;
    logic            r_busy;

    logic [N-1:0]    w_sliceA;
    logic [N-1:0]    w_sliceB;
    logic [N-1:0]    w_sliceSum;
    logic            w_sliceCout;

    // Select the operand slice addressed by the current slice counter.
    always_comb begin
        w_sliceA = r_opA[int'(r_cnt) * N +: N];
        w_sliceB = r_opB[int'(r_cnt) * N +: N];
    end

    rca #(
        .N (N)
    ) u_rca (
        .i_a    (w_sliceA),
        .i_b    (w_sliceB),
        .i_cin  (r_carry),
        .o_sum  (w_sliceSum),
        .o_cout (w_sliceCout)
    );

    // Sequencer FSM: capture operands, step through the slices, then hold
    // the result until the consumer takes it. Handshake flags are registered
    // alongside the state so they never glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_carry    <= 1'b0;
            r_opA      <= '0;
            r_opB      <= '0;
            r_sum      <= '0;
            r_cout     <= 1'b0;
            r_inReady  <= 1'b1;
            r_outValid <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && r_inReady) begin
                        r_opA     <= a;
                        r_opB     <= b;
                        r_carry   <= cin;
                        r_cnt     <= '0;
                        r_state   <= RUN;
                        r_inReady <= 1'b0;
                        r_busy    <= 1'b1;
                    end
                end
                RUN: begin
                    r_sum[int'(r_cnt) * N +: N] <= w_sliceSum;
                    r_carry <= w_sliceCout;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == LAST_SLICE) begin
                        r_cout     <= w_sliceCout;
                        r_state    <= DONE;
                        r_outValid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state    <= IDLE;
                        r_outValid <= 1'b0;
                        r_busy     <= 1'b0;
                        r_inReady  <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_inReady  <= 1'b1;
                    r_outValid <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_inReady;
    assign out_valid = r_outValid;
    assign busy      = r_busy;
    assign sum       = r_sum;
    assign cout      = r_cout;

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// tb_rca_seq_ctrl: directed tests for rca_seq_ctrl with a transaction-level
// reference model (a + b + cin, K-cycle latency) checked on every cycle,
// plus a second W=N=32 instance for the single-slice case.
module tb_rca_seq_ctrl;

    localparam int W = 32;
    localparam int N = 8;
    localparam int K = W / N;

    logic         clk = 1'b0;
    logic         rstN;

    logic         inValid, inReady, outValid, outReady, cin, cout, busy;
    logic [W-1:0] a, b, sum;

    logic         inValid1, inReady1, outValid1, outReady1, cin1, cout1, busy1;
    logic [W-1:0] a1, b1, sum1;

    int nVectors    = 0;
    int nMiscompares = 0;

    // Reference model state (transaction level).
    bit           mInFlight   = 1'b0;
    int           mAge        = 0;
    bit           mAcceptNext = 1'b0;
    bit           mHandNext   = 1'b0;
    logic [W:0]   mExp        = '0;
    int           nResults    = 0;

    always #5 clk = ~clk;

    rca_seq_ctrl #(.W(W), .N(N)) dut (
        .clk       (clk),
        .rst_n     (rstN),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (outValid),
        .out_ready (outReady),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    rca_seq_ctrl #(.W(32), .N(32)) dutWide (
        .clk       (clk),
        .rst_n     (rstN),
        .in_valid  (inValid1),
        .in_ready  (inReady1),
        .a         (a1),
        .b         (b1),
        .cin       (cin1),
        .out_valid (outValid1),
        .out_ready (outReady1),
        .sum       (sum1),
        .cout      (cout1),
        .busy      (busy1)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        nVectors++;
        if (actual !== expected) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic recordTimeout(input string name);
        nVectors++;
        nMiscompares++;
        $display("[TB] FAIL %s: bound expired, got no event, expected one", name);
    endtask

    // One stimulus step: wait for a rising edge, then drive away from it.
    task automatic applyStimulus(input logic [W-1:0] va, input logic [W-1:0] vb,
                                 input logic vcin, input logic vValid, input logic vReady);
        @(posedge clk);
        #2;
        a        = va;
        b        = vb;
        cin      = vcin;
        inValid  = vValid;
        outReady = vReady;
    endtask

    task automatic waitResult(output logic [W-1:0] s, output logic c, output int lat);
        lat = -1;
        s   = '0;
        c   = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (outValid) begin
                lat = i;
                s   = sum;
                c   = cout;
                break;
            end
        end
        if (lat < 0) recordTimeout("result wait");
    endtask

    task automatic waitAccept(output int t);
        bit found;
        found = 1'b0;
        t     = 0;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            if (inReady && inValid) begin
                @(posedge clk);
                t     = int'($time);
                found = 1'b1;
                break;
            end
        end
        if (!found) recordTimeout("accept wait");
    endtask

    // Model and compare: at each falling edge, account for what the last
    // rising edge did, compare the DUT against it, then decide from the
    // current inputs what the next rising edge will do.
    always @(negedge clk) begin
        if (!rstN) begin
            mInFlight   = 1'b0;
            mAge        = 0;
            mAcceptNext = 1'b0;
            mHandNext   = 1'b0;
            checkOutput("reset out_valid", 64'(outValid), 64'(0));
            checkOutput("reset busy", 64'(busy), 64'(0));
            checkOutput("reset sum", 64'(sum), 64'(0));
            checkOutput("reset cout", 64'(cout), 64'(0));
        end else begin
            bit expValid;
            if (mAcceptNext) begin
                mInFlight = 1'b1;
                mAge      = 0;
            end else if (mInFlight) begin
                if (mHandNext) begin
                    mInFlight = 1'b0;
                    nResults++;
                end else begin
                    mAge++;
                end
            end
            expValid = mInFlight && (mAge >= K);
            checkOutput("in_ready", 64'(inReady), 64'(!mInFlight));
            checkOutput("out_valid", 64'(outValid), 64'(expValid));
            checkOutput("busy", 64'(busy), 64'(mInFlight));
            if (expValid) begin
                checkOutput("sum", 64'(sum), 64'(mExp[W-1:0]));
                checkOutput("cout", 64'(cout), 64'(mExp[W]));
            end
            mAcceptNext = !mInFlight && inValid;
            if (mAcceptNext) mExp = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
            mHandNext = expValid && outReady;
        end
    end

    // Hard stop so a wedged DUT can never hang the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test sequence.
    initial begin
        logic [W-1:0] rs;
        logic         rc;
        int           lat;
        int           acc [3];
        bit           seen;

        rstN = 1'b0;
        inValid = 1'b0; outReady = 1'b0; a = '0; b = '0; cin = 1'b0;
        inValid1 = 1'b0; outReady1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        repeat (2) @(posedge clk);
        #2 rstN = 1'b1;

        // Abort mid-RUN with reset: no result must ever appear for it.
        applyStimulus(32'h1, 32'h0, 1'b0, 1'b1, 1'b1);
        applyStimulus(32'h1, 32'h0, 1'b0, 1'b0, 1'b1);
        applyStimulus(32'h1, 32'h0, 1'b0, 1'b0, 1'b1);
        applyStimulus(32'h1, 32'h0, 1'b0, 1'b0, 1'b1);
        rstN = 1'b0;
        #1;
        checkOutput("abort out_valid", 64'(outValid), 64'(0));
        checkOutput("abort sum", 64'(sum), 64'(0));
        checkOutput("abort cout", 64'(cout), 64'(0));
        checkOutput("abort busy", 64'(busy), 64'(0));
        @(posedge clk);
        #2 rstN = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        checkOutput("abort in_ready", 64'(inReady), 64'(1));
        checkOutput("abort no result", 64'(nResults), 64'(0));
        checkOutput("wide idle in_ready", 64'(inReady1), 64'(1));

        // Carry ripples through every slice.
        applyStimulus(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1);
        applyStimulus(32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        waitResult(rs, rc, lat);
        checkOutput("ripple latency", 64'(lat), 64'(4));
        checkOutput("ripple sum", 64'(rs), 64'h0000_0000);
        checkOutput("ripple cout", 64'(rc), 64'(1));

        // Mixed operands with carry-in; busy from the first RUN edge on.
        applyStimulus(32'h1234_5678, 32'h8765_4321, 1'b1, 1'b1, 1'b1);
        applyStimulus(32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        checkOutput("mixed busy after accept", 64'(busy), 64'(1));
        waitResult(rs, rc, lat);
        checkOutput("mixed sum", 64'(rs), 64'h9999_999A);
        checkOutput("mixed cout", 64'(rc), 64'(0));
        checkOutput("mixed busy in DONE", 64'(busy), 64'(1));

        // Backpressure with a second request waiting.
        applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0);
        applyStimulus(32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        waitResult(rs, rc, lat);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checkOutput("stall sum", 64'(sum), 64'hFFFF_FFFF);
            checkOutput("stall cout", 64'(cout), 64'(1));
            checkOutput("stall in_ready", 64'(inReady), 64'(0));
        end
        #1 outReady = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("release in_ready", 64'(inReady), 64'(1));
        checkOutput("release out_valid", 64'(outValid), 64'(0));
        @(posedge clk);
        #1 inValid = 1'b0;
        waitResult(rs, rc, lat);
        checkOutput("second op sum", 64'(rs), 64'h0);
        checkOutput("second op cout", 64'(rc), 64'(0));

        // Back-to-back with in_valid held high.
        applyStimulus(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            waitAccept(acc[i]);
            #2;
            if (i < 2) begin
                a   = W'($urandom);
                b   = W'($urandom);
                cin = 1'($urandom_range(0, 1));
            end else begin
                inValid = 1'b0;
            end
        end
        checkOutput("b2b period 1", 64'(acc[1] - acc[0]), 64'(60));
        checkOutput("b2b period 2", 64'(acc[2] - acc[1]), 64'(60));
        waitResult(rs, rc, lat);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("result count", 64'(nResults), 64'(7));

        // Single-slice instance.
        @(posedge clk);
        #2;
        a1 = 32'h7FFF_FFFF; b1 = 32'h1; cin1 = 1'b0; inValid1 = 1'b1; outReady1 = 1'b1;
        @(posedge clk);
        #2 inValid1 = 1'b0;
        checkOutput("wide busy", 64'(busy1), 64'(1));
        seen = 1'b0;
        lat  = -1;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1;
            if (outValid1) begin
                lat  = i;
                seen = 1'b1;
                checkOutput("wide sum", 64'(sum1), 64'h8000_0000);
                checkOutput("wide cout", 64'(cout1), 64'(0));
                break;
            end
        end
        if (!seen) recordTimeout("wide result wait");
        checkOutput("wide latency", 64'(lat), 64'(1));
        @(posedge clk);
        #1;
        checkOutput("wide back to idle", 64'(inReady1), 64'(1));

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
